rsa_modexp_ctrl: RTL
====================

Name: rsa_modexp_ctrl

Overview:
Sequencer that computes result = data^key mod modulus by right-to-left binary square-and-multiply. It drives the shared modular-multiply datapath (mult followed by modulo) through a req/ack handshake. It sits between the board-level start/data/key inputs and the modmul datapath, and replaces free-running counter-driven sequencing with explicit per-operation control. It reports completion with a one-cycle valid pulse and flags illegal operands.

Parameters:
BUS_WIDTH, 6, width of data, key, modulus, result and all datapath operands.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  request a new exponentiation; accepted only in IDLE.
data  input  BUS_WIDTH  base (plaintext or ciphertext).
key  input  BUS_WIDTH  exponent (e or d).
modulus  input  BUS_WIDTH  N.
busy  output  1  high from the cycle after start is accepted until DONE exits.
valid  output  1  one-cycle pulse; result and err are meaningful in that cycle.
result  output  BUS_WIDTH  final value; held until the next valid.
err  output  1  qualified by valid; modulus<2 or data>=modulus.
mm_req  output  1  modmul request.
mm_a  output  BUS_WIDTH  modmul operand A.
mm_b  output  BUS_WIDTH  modmul operand B.
mm_ack  input  1  modmul done; mm_p is valid in the same cycle.
mm_p  input  BUS_WIDTH  (mm_a*mm_b) mod modulus.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, valid, err, mm_req = 0; result, mm_a, mm_b = 0; internal acc, base, exp, bitcnt = 0.
- Registers: acc, base, exp (all BUS_WIDTH); bitcnt (clog2(BUS_WIDTH) bits, minimum 1); n_reg.
- IDLE: when start=1, capture data→base, key→exp, modulus→n_reg, set acc=1 and bitcnt=0, then go to CHECK. start is ignored in every other state, including while busy.
- CHECK (1 cycle): if n_reg<2 or base>=n_reg, set err=1 and result=0, then go to DONE. Otherwise go to BIT.
- BIT (1 cycle): if exp[0]=1 go to MUL, else go to SQR.
- MUL: mm_req=1, mm_a=acc, mm_b=base; these hold stable until mm_ack. On mm_ack: acc<=mm_p, mm_req<=0, go to SQR.
- SQR: mm_req=1, mm_a=mm_b=base. On mm_ack: base<=mm_p, exp<=exp>>1, bitcnt++. If bitcnt==BUS_WIDTH-1 (pre-increment), go to DONE; else go to BIT.
- mm_ack is sampled only while mm_req=1; mm_ack with mm_req=0 is ignored. mm_req deasserts for at least one cycle between consecutive operations.
- DONE (1 cycle): valid=1; result=acc unless err; busy=0 on the next cycle; go to IDLE. err clears on the next accepted start.
- key=0: no MUL is issued and result=1.
- Latency, no optional feature, with a k-cycle ack: 2 + BUS_WIDTH*(1 + (k+1)) + popcount(key)*(k+1) cycles from start to valid.
- Reset mid-operation aborts immediately; no valid is produced.

Optional Feature:
MODEXP_EARLY_EXIT_EN:
- Defined: after each SQR ack, if the shifted exp==0, go directly to DONE. The trailing squarings are skipped and latency depends on the key.
- Undefined: always BUS_WIDTH iterations. Latency depends only on popcount(key); the timing-leak reduction is the default.

Decomposition:
- Package rsa_pkg: BUS_WIDTH default, state enum localparams (IDLE, CHECK, BIT, MUL, SQR, DONE), CNT_W function.
- One sub-module, modexp_exp_shifter: holds exp and bitcnt, provides load/shift, and outputs lsb, last and exp_zero.

Test Plan:
- data=2, key=7, modulus=33, 1-cycle ack stub → valid with result=29, err=0; exactly 3 MUL and 6 SQR requests.
- data=5, key=3, modulus=33 → result=26. data=9, key=0, modulus=33 → result=1 with zero MUL requests.
- modulus=1 or data=40 with modulus=33 → valid within 3 cycles of start, err=1, result=0, no mm_req.
- start pulsed mid-run, and mm_ack stalled 5 cycles → start is ignored and mm_a/mm_b stay stable while mm_req=1; result is still 29 for the first case.
- rst low during SQR → all outputs 0 asynchronously. The next start with 2/7/33 yields 29.
- With MODEXP_EARLY_EXIT_EN, key=3 (BUS_WIDTH=6) → 2 SQR requests instead of 6, same result; without it, the cycle count matches the latency formula.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width default, sequencer states and counter-width helper for rsa_modexp_ctrl.
package rsa_pkg;
    localparam int DEF_BUS_WIDTH = 6;

    typedef enum logic [2:0] {IDLE, CHECK, BIT, MUL, SQR, DONE} state_t;

    function automatic int CNT_W(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/modexp_exp_shifter.sv
// modexp_exp_shifter: exponent shift register and bit counter for right-to-left square-and-multiply.
module modexp_exp_shifter
    import rsa_pkg::*;
#(
    parameter int W  = DEF_BUS_WIDTH,
    parameter int CW = CNT_W(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] key,
    output logic         lsb,
    output logic         last,
    output logic         exp_zero
);
    logic [W-1:0]  exp;
    logic [CW-1:0] bitcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp    <= '0;
            bitcnt <= '0;
        end else if (load) begin
            exp    <= key;
            bitcnt <= '0;
        end else if (shift) begin
            exp    <= exp >> 1;
            bitcnt <= bitcnt + 1'b1;
        end
    end

    assign lsb      = exp[0];
    assign last     = bitcnt == CW'(W - 1);
    // Looks at the exponent as it will be after the pending shift.
    assign exp_zero = (exp >> 1) == '0;
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: square-and-multiply sequencer driving a shared modmul datapath over req/ack.
// Define MODEXP_EARLY_EXIT_EN to stop once the remaining exponent is zero (key-dependent latency).
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] data,
    input  logic [BUS_WIDTH-1:0] key,
    input  logic [BUS_WIDTH-1:0] modulus,
    output logic                 busy,
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 err,
    output logic                 mm_req,
    output logic [BUS_WIDTH-1:0] mm_a,
    output logic [BUS_WIDTH-1:0] mm_b,
    input  logic                 mm_ack,
    input  logic [BUS_WIDTH-1:0] mm_p
);
    state_t               state;
    logic [BUS_WIDTH-1:0] acc, base, n_reg;
    logic                 lsb, last, exp_zero, finish;
    logic                 load, shift, ack;

    assign ack   = mm_req && mm_ack;
    assign load  = state == IDLE && start;
    assign shift = state == SQR && ack;
`ifdef MODEXP_EARLY_EXIT_EN
    assign finish = last || exp_zero;
`else
    assign finish = last;
`endif

    modexp_exp_shifter #(.W(BUS_WIDTH)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .key      (key),
        .lsb      (lsb),
        .last     (last),
        .exp_zero (exp_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            mm_req <= 1'b0;
            mm_a   <= '0;
            mm_b   <= '0;
            acc    <= '0;
            base   <= '0;
            n_reg  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base  <= data;
                    n_reg <= modulus;
                    acc   <= BUS_WIDTH'(1);
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (n_reg < BUS_WIDTH'(2) || base >= n_reg) begin
                    err    <= 1'b1;
                    result <= '0;
                    valid  <= 1'b1;
                    state  <= DONE;
                end else begin
                    state <= BIT;
                end
                BIT: state <= lsb ? MUL : SQR;
                // Operands are latched once on entry, so they cannot move while the request is pending.
                MUL: if (!mm_req) begin
                    mm_req <= 1'b1;
                    mm_a   <= acc;
                    mm_b   <= base;
                end else if (mm_ack) begin
                    acc    <= mm_p;
                    mm_req <= 1'b0;
                    state  <= SQR;
                end
                SQR: if (!mm_req) begin
                    mm_req <= 1'b1;
                    mm_a   <= base;
                    mm_b   <= base;
                end else if (mm_ack) begin
                    base   <= mm_p;
                    mm_req <= 1'b0;
                    result <= finish ? acc : result;
                    valid  <= finish;
                    state  <= finish ? DONE : BIT;
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
